// File: rtl/inst_sequencer_pkg.sv
// Shared opcodes, instruction field positions, flag indices and sequencer states.
package inst_sequencer_pkg;

  localparam int FIELD_W = 5;

  localparam logic [FIELD_W-1:0] OP_JMP = 5'b10001;
  localparam logic [FIELD_W-1:0] OP_JC  = 5'b10010;
  localparam logic [FIELD_W-1:0] OP_JNC = 5'b10011;
  localparam logic [FIELD_W-1:0] OP_JZ  = 5'b10100;
  localparam logic [FIELD_W-1:0] OP_JNZ = 5'b10101;
  localparam logic [FIELD_W-1:0] OP_HLT = 5'b10110;

  localparam int OP_MSB       = 31;
  localparam int RDST_MSB     = 26;
  localparam int RSRC1_MSB    = 21;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_MSB    = 15;

  localparam int FLAG_W     = 2;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    ISSUE,
    NEXT,
    HALT
  } seq_state_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational instruction decode: field extraction, jump/halt detection and
// branch resolution against the current execute flags.
module inst_field_decode
  import inst_sequencer_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [INST_W-1:0]  ir,
  input  logic [FLAG_W-1:0]  flags,
  output logic [FIELD_W-1:0] op,
  output logic [FIELD_W-1:0] rdst,
  output logic [FIELD_W-1:0] rsrc1,
  output logic               imm_mode,
  output logic [FIELD_W-1:0] rsrc2,
  output logic [IMM_W-1:0]   imm,
  output logic               is_jump,
  output logic               is_halt,
  output logic               taken
);

  always_comb begin
    op       = ir[OP_MSB -: FIELD_W];
    rdst     = ir[RDST_MSB -: FIELD_W];
    rsrc1    = ir[RSRC1_MSB -: FIELD_W];
    imm_mode = ir[IMM_MODE_BIT];
    rsrc2    = ir[RSRC2_MSB -: FIELD_W];
    imm      = ir[IMM_W-1:0];
    is_halt  = (op == OP_HLT);
    is_jump  = 1'b0;
    taken    = 1'b0;
    case (op)
      OP_JMP: begin is_jump = 1'b1; taken = 1'b1;               end
      OP_JC:  begin is_jump = 1'b1; taken = flags[FLAG_CARRY];  end
      OP_JNC: begin is_jump = 1'b1; taken = !flags[FLAG_CARRY]; end
      OP_JZ:  begin is_jump = 1'b1; taken = flags[FLAG_ZERO];   end
      OP_JNZ: begin is_jump = 1'b1; taken = !flags[FLAG_ZERO];  end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_sequencer.sv
// Program counter and instruction sequencing: fetch, decode, resolve jumps/halt
// locally, issue everything else over valid/ready; stalls in ISSUE while not ready.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int INST_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst_i,
  input  logic              zero_i,
  input  logic              carry_i,
  input  logic              issue_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] ir_o,
  output logic              issue_valid_o,
  output logic [4:0]        op_o,
  output logic [4:0]        rdst_o,
  output logic [4:0]        rsrc1_o,
  output logic              imm_mode_o,
  output logic [4:0]        rsrc2_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic              halted_o,
  output logic [31:0]       retired_o
);

  seq_state_t state_q, state_d;
  logic       taken_q;

  logic [FLAG_W-1:0]  flags;
  logic [FIELD_W-1:0] dec_op, dec_rdst, dec_rsrc1, dec_rsrc2;
  logic               dec_imm_mode, dec_is_jump, dec_is_halt, dec_taken;
  logic [IMM_W-1:0]   dec_imm;

  always_comb begin
    flags             = '0;
    flags[FLAG_ZERO]  = zero_i;
    flags[FLAG_CARRY] = carry_i;
  end

  inst_field_decode #(
    .INST_W (INST_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .ir       (ir_o),
    .flags    (flags),
    .op       (dec_op),
    .rdst     (dec_rdst),
    .rsrc1    (dec_rsrc1),
    .imm_mode (dec_imm_mode),
    .rsrc2    (dec_rsrc2),
    .imm      (dec_imm),
    .is_jump  (dec_is_jump),
    .is_halt  (dec_is_halt),
    .taken    (dec_taken)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (dec_is_halt)      state_d = HALT;
        else if (dec_is_jump) state_d = NEXT;
        else                  state_d = ISSUE;
      end
      ISSUE:  if (issue_ready_i) state_d = NEXT;
      NEXT:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Derived from state so an async reset drops valid without waiting for a clock.
  assign issue_valid_o = (state_q == ISSUE);
  assign halted_o      = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_o       <= '0;
      ir_o       <= '0;
      op_o       <= '0;
      rdst_o     <= '0;
      rsrc1_o    <= '0;
      imm_mode_o <= 1'b0;
      rsrc2_o    <= '0;
      imm_o      <= '0;
      taken_q    <= 1'b0;
      retired_o  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: ir_o <= inst_i;
        DECODE: begin
          op_o       <= dec_op;
          rdst_o     <= dec_rdst;
          rsrc1_o    <= dec_rsrc1;
          imm_mode_o <= dec_imm_mode;
          rsrc2_o    <= dec_rsrc2;
          imm_o      <= dec_imm;
          taken_q    <= dec_taken;
          if (dec_is_halt) retired_o <= retired_o + 32'd1;
        end
        NEXT: begin
          // Jump targets keep only the low address bits of the immediate.
          pc_o      <= taken_q ? imm_o[ADDR_W-1:0] : pc_o + ADDR_W'(1);
          retired_o <= retired_o + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: per-instruction cadence model plus directed programs.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_i;
  logic        zero_i = 1'b0, carry_i = 1'b0, issue_ready_i = 1'b1;
  logic [4:0]  pc_o;
  logic [31:0] ir_o;
  logic        issue_valid_o, imm_mode_o, halted_o;
  logic [4:0]  op_o, rdst_o, rsrc1_o, rsrc2_o;
  logic [15:0] imm_o;
  logic [31:0] retired_o;

  inst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .zero_i(zero_i), .carry_i(carry_i),
    .issue_ready_i(issue_ready_i), .pc_o(pc_o), .ir_o(ir_o), .issue_valid_o(issue_valid_o),
    .op_o(op_o), .rdst_o(rdst_o), .rsrc1_o(rsrc1_o), .imm_mode_o(imm_mode_o),
    .rsrc2_o(rsrc2_o), .imm_o(imm_o), .halted_o(halted_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  assign inst_i = mem[pc_o];

  int n_cmp = 0, n_err = 0, cyc = 0, valid_cnt = 0;
  bit prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic im,
                                      input logic [15:0] imm16);
    return {op, rd, rs1, im, imm16};
  endfunction

  // 0 = issued op, 1 = jump, 2 = halt
  function automatic int kind_of(input logic [31:0] w);
    logic [4:0] op;
    op = w[31:27];
    if (op == 5'b10110) return 2;
    if (op >= 5'b10001 && op <= 5'b10101) return 1;
    return 0;
  endfunction

  function automatic bit jump_taken(input logic [31:0] w, input bit z, input bit c);
    case (w[31:27])
      5'b10001: return 1'b1;
      5'b10010: return c;
      5'b10011: return !c;
      5'b10100: return z;
      5'b10101: return !z;
      default:  return 1'b0;
    endcase
  endfunction

  // Model: m_step counts cycles since the instruction's fetch cycle.
  logic [4:0]  m_pc;
  logic [31:0] m_w, m_ret;
  int          m_step;
  bit          m_taken, m_xfer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 5'd0; m_step <= 0; m_w <= 32'd0; m_ret <= 32'd0;
      m_taken <= 1'b0; m_xfer <= 1'b0;
    end else if (m_step == 0) begin
      m_w <= mem[m_pc];
      m_step <= 1;
    end else if (m_step == 1) begin
      m_step <= 2;
      if (kind_of(m_w) == 2) m_ret <= m_ret + 32'd1;
      m_taken <= (kind_of(m_w) == 1) && jump_taken(m_w, zero_i, carry_i);
    end else begin
      case (kind_of(m_w))
        2: ;
        1: begin
          m_pc <= m_taken ? m_w[4:0] : m_pc + 5'd1;
          m_ret <= m_ret + 32'd1;
          m_step <= 0;
        end
        default: begin
          if (!m_xfer) begin
            if (issue_ready_i) m_xfer <= 1'b1;
          end else begin
            m_pc <= m_pc + 5'd1;
            m_ret <= m_ret + 32'd1;
            m_xfer <= 1'b0;
            m_step <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int  k;
      bit  exp_valid, exp_halt;
      k = kind_of(m_w);
      exp_valid = (m_step >= 2) && (k == 0) && !m_xfer;
      exp_halt  = (m_step >= 2) && (k == 2);
      chk("pc", 32'(pc_o), 32'(m_pc));
      chk("ir", ir_o, m_w);
      chk("valid", 32'(issue_valid_o), 32'(exp_valid));
      chk("halted", 32'(halted_o), 32'(exp_halt));
      chk("retired", retired_o, m_ret);
      if (exp_valid) begin
        chk("op", 32'(op_o), 32'(m_w[31:27]));
        chk("rdst", 32'(rdst_o), 32'(m_w[26:22]));
        chk("rsrc1", 32'(rsrc1_o), 32'(m_w[21:17]));
        chk("imm_mode", 32'(imm_mode_o), 32'(m_w[16]));
        chk("rsrc2", 32'(rsrc2_o), 32'(m_w[15:11]));
        chk("imm", 32'(imm_o), 32'(m_w[15:0]));
      end
      if (issue_valid_o && !prev_valid) valid_cnt++;
      prev_valid = issue_valid_o;
    end
  end

  task automatic reset_on();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_ir", ir_o, 32'd0);
    chk("rst_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_fields", {op_o, rdst_o, rsrc1_o, imm_mode_o, imm_o}, 32'd0);
    issue_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = enc(5'b10110, 5'd0, 5'd0, 1'b0, 16'd0);
  endtask

  task automatic reset_off();
    repeat (2) @(posedge clk);
    #2;
    valid_cnt = 0;
    prev_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [4:0] p, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pc_o === p) begin t = cyc; break; end
    end
    if (t < 0) chk("wait_pc_timeout", 32'(pc_o), 32'(p));
  endtask

  task automatic wait_valid();
    int hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (issue_valid_o) begin hit = 1; break; end
    end
    if (hit == 0) chk("wait_valid_timeout", 32'(issue_valid_o), 32'd1);
  endtask

  task automatic wait_halt();
    int hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (halted_o) begin hit = 1; break; end
    end
    if (hit == 0) chk("wait_halt_timeout", 32'(halted_o), 32'd1);
  endtask

  logic [4:0]  j_op  [5] = '{5'b10100, 5'b10100, 5'b10011, 5'b10011, 5'b10101};
  bit          j_z   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit          j_c   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] j_imm [5] = '{16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'hFFE7};
  logic [4:0]  j_exp [5] = '{5'd4, 5'd7, 5'd7, 5'd4, 5'd7};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;

    // 1: three ALU ops back to back, ready always high
    reset_on();
    mem[0] = enc(5'b00001, 5'd3, 5'd1, 1'b0, {5'd2, 11'd0});
    mem[1] = enc(5'b00001, 5'd7, 5'd4, 1'b1, 16'hBEEF);
    mem[2] = enc(5'b00001, 5'd31, 5'd30, 1'b0, 16'h1234);
    reset_off();
    wait_pc(5'd0, t0);
    wait_valid();
    chk("s1_rdst0", 32'(rdst_o), 32'd3);
    chk("s1_rsrc2_0", 32'(rsrc2_o), 32'd2);
    wait_pc(5'd1, t1);
    chk("s1_spacing01", 32'(t1 - t0), 32'd4);
    wait_pc(5'd2, t2);
    chk("s1_spacing12", 32'(t2 - t1), 32'd4);
    wait_pc(5'd3, t0);
    chk("s1_retired", retired_o, 32'd3);
    chk("s1_issues", 32'(valid_cnt), 32'd3);

    // 2: three ready-low cycles on the op at pc 1
    reset_on();
    mem[0] = enc(5'b00001, 5'd1, 5'd2, 1'b0, 16'h0001);
    mem[1] = enc(5'b00011, 5'd9, 5'd5, 1'b1, 16'hA5A5);
    reset_off();
    wait_pc(5'd1, t1);
    wait_valid();
    issue_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("s2_stall_valid", 32'(issue_valid_o), 32'd1);
    chk("s2_stall_rdst", 32'(rdst_o), 32'd9);
    chk("s2_stall_imm", 32'(imm_o), 32'hA5A5);
    chk("s2_stall_pc", 32'(pc_o), 32'd1);
    issue_ready_i = 1'b1;
    wait_pc(5'd2, t2);
    chk("s2_len", 32'(t2 - t1), 32'd7);
    chk("s2_issues", 32'(valid_cnt), 32'd2);
    chk("s2_retired", retired_o, 32'd2);

    // 3: unconditional jump
    reset_on();
    mem[0] = enc(5'b00001, 5'd1, 5'd1, 1'b0, 16'd0);
    mem[1] = enc(5'b00001, 5'd2, 5'd2, 1'b0, 16'd0);
    mem[2] = enc(5'b10001, 5'd0, 5'd0, 1'b0, 16'h0009);
    reset_off();
    wait_pc(5'd2, t2);
    wait_pc(5'd9, t1);
    chk("s3_jmp_len", 32'(t1 - t2), 32'd3);
    chk("s3_issues", 32'(valid_cnt), 32'd2);

    // 4: conditional jumps at pc 3 (last entry checks target truncation)
    for (int j = 0; j < 5; j++) begin
      reset_on();
      zero_i = j_z[j];
      carry_i = j_c[j];
      for (int i = 0; i < 3; i++) mem[i] = enc(5'b00001, 5'(i), 5'd0, 1'b0, 16'd0);
      mem[3] = enc(j_op[j], 5'd0, 5'd0, 1'b0, j_imm[j]);
      reset_off();
      wait_halt();
      chk($sformatf("s4_target_%0d", j), 32'(pc_o), 32'(j_exp[j]));
    end
    zero_i = 1'b0;
    carry_i = 1'b0;

    // 5: halt at pc 4
    reset_on();
    for (int i = 0; i < 4; i++) mem[i] = enc(5'b00010, 5'(i + 1), 5'd0, 1'b0, 16'd0);
    reset_off();
    wait_pc(5'd4, t0);
    @(negedge clk);
    chk("s5_halt_early", 32'(halted_o), 32'd0);
    @(negedge clk);
    chk("s5_halt", 32'(halted_o), 32'd1);
    repeat (20) @(negedge clk);
    chk("s5_pc_hold", 32'(pc_o), 32'd4);
    chk("s5_issues", 32'(valid_cnt), 32'd4);
    chk("s5_retired", retired_o, 32'd5);

    // 6: wrap 31 -> 0, then reset while stalled in ISSUE
    reset_on();
    mem[0]  = enc(5'b10001, 5'd0, 5'd0, 1'b0, 16'h001F);
    mem[31] = enc(5'b00001, 5'd4, 5'd4, 1'b0, 16'h0042);
    reset_off();
    wait_pc(5'd31, t0);
    wait_pc(5'd0, t1);
    chk("s6_wrap_len", 32'(t1 - t0), 32'd4);
    issue_ready_i = 1'b0;
    wait_pc(5'd31, t0);
    wait_valid();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(issue_valid_o), 32'd0);
    chk("s6_rst_pc", 32'(pc_o), 32'd0);
    chk("s6_rst_retired", retired_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
